route_table_arbiter: RTL and testbench

// Owns the router's routing table and shares it among the PORTS input

---
 rtl/route_table_arbiter_if.sv | 26 ++
 rtl/route_table_arbiter.sv | 89 ++++++++
 tb/tb_route_table_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/route_table_arbiter_if.sv
// Lookup/config bus of the routing-table arbiter: one config write port plus
// PORTS independent 4-phase lookup channels with their results.
interface route_table_arbiter_if #(
    parameter int PORTS     = 5,
    parameter int PORT_BITS = 8,
    parameter int DEST_BITS = 7
);
    logic                           cfg_we;
    logic [DEST_BITS-1:0]           cfg_addr;
    logic [PORT_BITS-1:0]           cfg_data;
    logic [PORTS-1:0]               lk_req;
    logic [PORTS*DEST_BITS-1:0]     lk_addr;
    logic [PORTS-1:0]               lk_ack;
    logic [PORTS*PORT_BITS-1:0]     lk_port;
    logic                           ready;

    modport master (
        output cfg_we, cfg_addr, cfg_data, lk_req, lk_addr,
        input  lk_ack, lk_port, ready
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, lk_req, lk_addr,
        output lk_ack, lk_port, ready
    );
endinterface

// File: rtl/route_table_arbiter.sv
// Routing table shared by PORTS lookup requesters: init sweep to DEFAULT_PORT,
// then one access per cycle (config write first, else a round-robin lookup).
module route_table_arbiter #(
    parameter int PORTS        = 5,
    parameter int PORT_BITS    = 8,
    parameter int DEST_BITS    = 7,
    parameter int DEFAULT_PORT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    route_table_arbiter_if.slave  bus
);
    localparam int DESTS = 2 ** DEST_BITS;
    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t               state, state_nxt;
    logic [DEST_BITS-1:0] init_cnt;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PORT_BITS-1:0] table_mem [DESTS];

    logic [PORTS-1:0]     elig;
    logic                 grant_vld;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     cand;
    logic [DEST_BITS-1:0] rd_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_INIT;
        else       state <= state_nxt;
    end

    // Next state and grant selection; a config write owns the table port.
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        elig      = bus.lk_req & ~bus.lk_ack;
        case (state)
            S_INIT: begin
                if (init_cnt == DEST_BITS'(DESTS - 1)) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!bus.cfg_we) begin
                    for (int k = 0; k < PORTS; k++) begin
                        cand = PTR_W'((int'(rr_ptr) + k) % PORTS);
                        if (!grant_vld && elig[cand]) begin
                            grant_vld = 1'b1;
                            grant_idx = cand;
                        end
                    end
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    assign rd_addr = bus.lk_addr[int'(grant_idx)*DEST_BITS +: DEST_BITS];

    // Table storage: sweep writes during INIT, config writes in RUN.
    always_ff @(posedge clk) begin
        if (state == S_INIT)
            table_mem[init_cnt] <= PORT_BITS'(DEFAULT_PORT);
        else if (bus.cfg_we)
            table_mem[bus.cfg_addr] <= bus.cfg_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_cnt    <= '0;
            rr_ptr      <= '0;
            bus.lk_ack  <= '0;
            bus.lk_port <= '0;
            bus.ready   <= 1'b0;
        end else begin
            if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
            bus.ready <= (state_nxt == S_RUN);
            // Acks clear as soon as their request drops, independent of the grant.
            bus.lk_ack <= bus.lk_ack & bus.lk_req;
            if (grant_vld) begin
                bus.lk_ack[grant_idx] <= 1'b1;
                bus.lk_port[int'(grant_idx)*PORT_BITS +: PORT_BITS] <= table_mem[rd_addr];
                rr_ptr <= (int'(grant_idx) == PORTS - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_route_table_arbiter.sv
// Directed bench for route_table_arbiter: expected grants are queued when a
// request is raised and checked in order as acknowledges rise.
module tb_route_table_arbiter;
    localparam int PORTS        = 5;
    localparam int PORT_BITS    = 8;
    localparam int DEST_BITS    = 7;
    localparam int DEFAULT_PORT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    route_table_arbiter_if #(.PORTS(PORTS), .PORT_BITS(PORT_BITS), .DEST_BITS(DEST_BITS)) bus ();

    route_table_arbiter #(
        .PORTS(PORTS), .PORT_BITS(PORT_BITS), .DEST_BITS(DEST_BITS), .DEFAULT_PORT(DEFAULT_PORT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {int port; int val;} exp_t;
    exp_t exp_q[$];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PORT_BITS-1:0] port_val(int p);
        return bus.lk_port[p*PORT_BITS +: PORT_BITS];
    endfunction

    task automatic set_req(int p, int addr);
        bus.lk_addr[p*DEST_BITS +: DEST_BITS] = DEST_BITS'(addr);
        bus.lk_req[p] = 1'b1;
    endtask

    task automatic push_exp(int p, int v);
        exp_t e;
        e.port = p;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // One new ack must rise on each of the next n edges, in queue order.
    task automatic expect_grants(string tag, int n);
        for (int g = 0; g < n; g++) begin
            logic [PORTS-1:0] prev;
            logic [PORTS-1:0] rose;
            int idx;
            exp_t e;
            prev = bus.lk_ack;
            tick();
            rose = bus.lk_ack & ~prev;
            check({tag, " onehot"}, $countones(rose), 1);
            idx = -1;
            for (int i = 0; i < PORTS; i++) if (rose[i] && idx < 0) idx = i;
            if (exp_q.size() == 0) begin
                check({tag, " queue"}, 0, 1);
            end else begin
                e = exp_q.pop_front();
                check({tag, " port"}, idx, e.port);
                check({tag, " value"}, (idx < 0) ? -1 : int'(port_val(idx)), e.val);
            end
        end
    endtask

    task automatic lookup(string tag, int p, int addr, int exp_v);
        push_exp(p, exp_v);
        set_req(p, addr);
        expect_grants(tag, 1);
        bus.lk_req[p] = 1'b0;
        tick();
        check({tag, " release"}, bus.lk_ack[p], 0);
    endtask

    task automatic cfg_write(int addr, int data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = DEST_BITS'(addr);
        bus.cfg_data = PORT_BITS'(data);
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    initial begin
        logic early;
        logic ack_in_init;
        int   a1 [PORTS] = '{1, 2, 3, 0, 9};
        int   v1 [PORTS] = '{2, 1, 2, 4, 4};
        int   a2 [PORTS] = '{9, 3, 2, 1, 0};
        int   v2 [PORTS] = '{4, 2, 1, 2, 4};

        reset        = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.lk_req   = '0;
        bus.lk_addr  = '0;
        repeat (3) tick();
        check("reset ready", bus.ready, 0);
        check("reset ack", bus.lk_ack, 0);
        check("reset port", bus.lk_port, 0);

        // T1: sweep timing; lookup request and config write during INIT
        #2 reset = 1'b0;
        early = 1'b0;
        ack_in_init = 1'b0;
        set_req(0, 7);
        for (int e = 1; e <= 128; e++) begin
            if (e == 100) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 7'd5;
                bus.cfg_data = 8'd9;
            end
            if (e == 101) bus.cfg_we = 1'b0;
            tick();
            if (e < 128 && bus.ready) early = 1'b1;
            if (bus.lk_ack != '0) ack_in_init = 1'b1;
        end
        check("T1 ready before 128", early, 0);
        check("T1 ready at 128", bus.ready, 1);
        check("T1 no ack in init", ack_in_init, 0);
        push_exp(0, DEFAULT_PORT);
        expect_grants("T1 pending req", 1);
        bus.lk_req[0] = 1'b0;
        tick();
        check("T1 pending release", bus.lk_ack[0], 0);
        lookup("T1 cfg in init ignored", 0, 5, DEFAULT_PORT);
        for (int r = 0; r < 4; r++)
            lookup("T1 random", int'($urandom_range(0, PORTS - 1)), int'($urandom_range(0, 127)), DEFAULT_PORT);

        // T2: config writes then lookups on port 0
        cfg_write(1, 2);
        cfg_write(2, 1);
        cfg_write(3, 2);
        lookup("T2 addr0", 0, 0, 4);
        lookup("T2 addr1", 0, 1, 2);
        lookup("T2 addr2", 0, 2, 1);
        lookup("T2 addr3", 0, 3, 2);
        lookup("T2 addr9", 0, 9, 4);

        // T3: all ports at once, round-robin from 0, twice
        lookup("T3 prime", 4, 3, 2);
        for (int i = 0; i < PORTS; i++) begin
            push_exp(i, v1[i]);
            set_req(i, a1[i]);
        end
        expect_grants("T3 round1", PORTS);
        check("T3 all acked", bus.lk_ack, 5'h1f);
        tick();
        check("T3 acks held", bus.lk_ack, 5'h1f);
        bus.lk_req = '0;
        tick();
        check("T3 all released", bus.lk_ack, 0);
        for (int i = 0; i < PORTS; i++) begin
            push_exp(i, v2[i]);
            set_req(i, a2[i]);
        end
        expect_grants("T3 round2", PORTS);
        bus.lk_req = '0;
        tick();
        check("T3 round2 released", bus.lk_ack, 0);

        // T4: config writes block a pending lookup on port 2
        push_exp(2, 7);
        set_req(2, 20);
        bus.cfg_we = 1'b1; bus.cfg_addr = 7'd20; bus.cfg_data = 8'd5;
        tick();
        check("T4 no ack cfg1", bus.lk_ack[2], 0);
        bus.cfg_addr = 7'd21; bus.cfg_data = 8'd6;
        tick();
        check("T4 no ack cfg2", bus.lk_ack[2], 0);
        bus.cfg_addr = 7'd20; bus.cfg_data = 8'd7;
        tick();
        check("T4 no ack cfg3", bus.lk_ack[2], 0);
        bus.cfg_we = 1'b0;
        expect_grants("T4 after cfg", 1);
        bus.lk_req[2] = 1'b0;
        tick();
        check("T4 release", bus.lk_ack[2], 0);
        lookup("T4 other addr", 3, 21, 6);

        // T6: held request gets exactly one grant
        push_exp(1, 1);
        set_req(1, 2);
        expect_grants("T6 grant", 1);
        for (int h = 0; h < 3; h++) begin
            tick();
            check("T6 ack held", bus.lk_ack, 5'b00010);
            check("T6 result held", port_val(1), 1);
        end
        bus.lk_req[1] = 1'b0;
        tick();
        check("T6 ack clears", bus.lk_ack[1], 0);
        lookup("T6 regrant", 1, 2, 1);

        // T5: reset mid-handshake, then again mid-sweep at init_cnt=50
        push_exp(0, 2);
        set_req(0, 1);
        expect_grants("T5 pre", 1);
        reset = 1'b1;
        #1;
        check("T5 async ack clear", bus.lk_ack, 0);
        check("T5 async ready clear", bus.ready, 0);
        #1 reset = 1'b0;
        bus.lk_req = '0;
        repeat (50) tick();
        check("T5 ready mid sweep", bus.ready, 0);
        reset = 1'b1;
        #2 reset = 1'b0;
        early = 1'b0;
        for (int e = 1; e <= 128; e++) begin
            tick();
            if (e < 128 && bus.ready) early = 1'b1;
        end
        check("T5 ready before 128", early, 0);
        check("T5 ready at 128", bus.ready, 1);
        lookup("T5 addr1 default", 0, 1, DEFAULT_PORT);
        lookup("T5 addr20 default", 2, 20, DEFAULT_PORT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
